cbd_secret_sampler: RTL

- Generates the small-secret coefficient stream consumed by the multiplier datapath, one coefficient per handshake, in sign-magnitude form: 3-bit magnitude plus sign, range [-4,+4].
- Takes 64-bit words of uniform randomness from the SHAKE/PRNG output, buffers one word, and applies a centered binomial distribution with mu=8 to each byte.
- Sits between the Keccak output stage and the polynomial multiplier's secret-operand port.

---
 rtl/cbd_secret_sampler_if.sv | 28 ++
 rtl/cbd_secret_sampler.sv | 126 ++++++++++++
 2 files changed

// File: rtl/cbd_secret_sampler_if.sv
// Handshake bundle between the randomness source, the CBD sampler and the
// multiplier secret-operand port.
interface cbd_secret_sampler_if #(
   parameter int RW = 64,
   parameter int CW = 8
);
   logic          start;
   logic [RW-1:0] rand_data;
   logic          rand_valid;
   logic          rand_ready;
   logic [2:0]    s;
   logic          s_sign;
   logic          s_valid;
   logic          s_ready;
   logic [CW-1:0] coeff_idx;
   logic          busy;
   logic          poly_done;

   modport master (
      output start, rand_data, rand_valid, s_ready,
      input  rand_ready, s, s_sign, s_valid, coeff_idx, busy, poly_done
   );

   modport slave (
      input  start, rand_data, rand_valid, s_ready,
      output rand_ready, s, s_sign, s_valid, coeff_idx, busy, poly_done
   );
endinterface

// File: rtl/cbd_secret_sampler.sv
// Centered-binomial (mu=8) secret sampler: buffers one randomness word and
// emits one sign-magnitude coefficient per byte, one per handshake.
//
// state | meaning
// IDLE  | waiting for start; no outputs active
// LOAD  | requesting a randomness word (rand_ready=1)
// EMIT  | presenting a coefficient from the buffered word (s_valid=1)
// DONE  | one-cycle poly_done pulse, then back to IDLE
module cbd_secret_sampler #(
   parameter int RW      = 64,
   parameter int N_COEFF = 256,
   parameter int CW      = 8
) (
   input logic                  clk,
   input logic                  rst,
   cbd_secret_sampler_if.slave  bus
);
   localparam int NB = RW / 8;
   localparam int SW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [SW-1:0] SLOT_LAST = SW'(NB - 1);
   localparam logic [CW-1:0] IDX_LAST  = CW'(N_COEFF - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_EMIT,
      S_DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [RW-1:0] rand_buf;
   logic [SW-1:0] slot;
   logic [CW-1:0] coeff_idx;

   logic [7:0]    byte_cur;
   logic [2:0]    pop_lo;
   logic [2:0]    pop_hi;
   logic          s_valid_c;
   logic          rand_ready_c;
   logic          xfer;
   logic          last_slot;
   logic          last_coeff;
   logic          load_word;

   function automatic logic [2:0] pop4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   always_comb begin
      byte_cur = '0;
      for (int i = 0; i < NB; i++) begin
         if (slot == SW'(i)) byte_cur = rand_buf[8*i +: 8];
      end
   end

   assign pop_lo = pop4(byte_cur[3:0]);
   assign pop_hi = pop4(byte_cur[7:4]);

   // Sign only when hi strictly exceeds lo, so a zero difference is never negative.
   assign bus.s      = (pop_lo >= pop_hi) ? (pop_lo - pop_hi) : (pop_hi - pop_lo);
   assign bus.s_sign = (pop_hi > pop_lo);

   assign s_valid_c  = (state == S_EMIT);
   assign xfer       = s_valid_c & bus.s_ready;
   assign last_slot  = (slot == SLOT_LAST);
   assign last_coeff = (coeff_idx == IDX_LAST);
   assign load_word  = rand_ready_c & bus.rand_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      rand_ready_c = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            rand_ready_c = 1'b1;
            if (bus.rand_valid) state_nxt = S_EMIT;
         end
         S_EMIT: begin
            // Refill on the final byte of a word so streaming has no bubble.
            if (last_slot && !last_coeff) rand_ready_c = bus.s_ready;
            if (xfer) begin
               if (last_coeff)                        state_nxt = S_DONE;
               else if (last_slot && !bus.rand_valid) state_nxt = S_LOAD;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rand_buf  <= '0;
         slot      <= '0;
         coeff_idx <= '0;
      end else begin
         if (state == S_IDLE && bus.start) coeff_idx <= '0;
         else if (xfer)                    coeff_idx <= coeff_idx + 1'b1;

         if (load_word) begin
            rand_buf <= bus.rand_data;
            slot     <= '0;
         end else if (xfer && !last_slot) begin
            slot <= slot + 1'b1;
         end
      end
   end

   assign bus.rand_ready = rand_ready_c;
   assign bus.s_valid    = s_valid_c;
   assign bus.coeff_idx  = coeff_idx;
   assign bus.busy       = (state == S_LOAD) || (state == S_EMIT);
   assign bus.poly_done  = (state == S_DONE);
endmodule
